multicycle_control_fsm: RTL and testbench

- Sequencing controller for the multicycle RV32I datapath variant. It replaces the single-cycle main decoder.
- It walks each instruction through fetch, decode, execute, memory and writeback states, one state per clock.
- It drives the datapath mux selects and write enables, and stalls on a memory-ready handshake.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, bne, jal. Any other opcode, or an unsupported branch funct3, parks the controller in a fault state.

---
 rtl/multicycle_control_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Sequencing controller for the multicycle RV32I datapath. Each instruction
//   passes through fetch, decode, execute, memory and writeback, one state per
//   clock. Fetch and data-memory states stall until mem_ready is high.
//   Supported: lw, sw, R-type, I-type ALU, beq, bne, jal. Anything else parks
//   the controller in FAULT until reset.
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   op, funct3, funct7b5 instruction fields from the instruction register
//   Zero                 ALU zero flag
//   mem_ready            memory finished the current access this cycle
//   PCWrite, IRWrite, RegWrite, MemWrite   write enables (held low in reset)
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl  datapath selects
//   fault                high while in FAULT
//   state_dbg            current state encoding
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | read instruction at PC, PC <= PC + 4 when mem_ready
// DECODE   | dispatch on op, ALUOut <= OldPC + imm (branch/jal target)
// MEMADR   | ALUOut <= rd1 + imm
// MEMREAD  | read data memory at ALUOut, wait for mem_ready
// MEMWB    | rd <= Data
// MEMWRITE | write data memory at ALUOut until mem_ready
// EXECR    | ALUOut <= rd1 op rd2
// EXECI    | ALUOut <= rd1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare rd1/rd2, PC <= target when taken
// JAL      | PC <= target, ALUOut <= OldPC + 4
// FAULT    | unsupported instruction, hold until reset
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd15
  } state_t;

  state_t     state, state_next;
  logic       pc_write, mem_write, ir_write, reg_write;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: state_next = S_MEMADR;
          7'b0110011:             state_next = S_EXECR;
          7'b0010011:             state_next = S_EXECI;
          7'b1100011:             state_next = (funct3[2:1] == 2'b00) ? S_BRANCH : S_FAULT;
          7'b1101111:             state_next = S_JAL;
          default:                state_next = S_FAULT;
        endcase
      end
      S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_FAULT:    state_next = S_FAULT;
      default:    state_next = S_FAULT;
    endcase
  end

  always_comb begin
    pc_write  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    alu_op    = 2'b00;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA  = 2'b10;
        alu_op   = 2'b01;
        // funct3[0] distinguishes bne from beq, so it inverts the zero test
        pc_write = Zero ^ funct3[0];
      end
      S_JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          // op[5] separates R-type sub from addi, whose imm can set bit 30
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  // Enables are masked directly by reset so nothing is written during the
  // reset cycle, even though the state register only clears at the edge.
  assign PCWrite   = pc_write  & ~reset;
  assign MemWrite  = mem_write & ~reset;
  assign IRWrite   = ir_write  & ~reset;
  assign RegWrite  = reg_write & ~reset;
  assign fault     = (state == S_FAULT);
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                 MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9,
                 JAL = 10, FAULTS = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'h33;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state_dbg;

  int tests = 0;
  int fails = 0;
  int exp_st[$];
  bit exp_mr[$];

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .fault(fault), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference plan: the list of states an instruction visits and the
  // mem_ready value presented in each of those cycles.
  task automatic build_plan(input logic [6:0] o, input logic [2:0] f3,
                            input int sf, input int sm);
    exp_st.delete();
    exp_mr.delete();
    for (int i = 0; i < sf; i++) begin exp_st.push_back(FETCH); exp_mr.push_back(1'b0); end
    exp_st.push_back(FETCH);  exp_mr.push_back(1'b1);
    exp_st.push_back(DECODE); exp_mr.push_back(rb());
    case (o)
      7'h03: begin
        exp_st.push_back(MEMADR); exp_mr.push_back(rb());
        for (int i = 0; i < sm; i++) begin exp_st.push_back(MEMREAD); exp_mr.push_back(1'b0); end
        exp_st.push_back(MEMREAD); exp_mr.push_back(1'b1);
        exp_st.push_back(MEMWB);   exp_mr.push_back(rb());
      end
      7'h23: begin
        exp_st.push_back(MEMADR); exp_mr.push_back(rb());
        for (int i = 0; i < sm; i++) begin exp_st.push_back(MEMWRITE); exp_mr.push_back(1'b0); end
        exp_st.push_back(MEMWRITE); exp_mr.push_back(1'b1);
      end
      7'h33: begin
        exp_st.push_back(EXECR); exp_mr.push_back(rb());
        exp_st.push_back(ALUWB); exp_mr.push_back(rb());
      end
      7'h13: begin
        exp_st.push_back(EXECI); exp_mr.push_back(rb());
        exp_st.push_back(ALUWB); exp_mr.push_back(rb());
      end
      7'h63: begin
        exp_st.push_back((f3 == 3'd0 || f3 == 3'd1) ? BRANCH : FAULTS);
        exp_mr.push_back(rb());
      end
      7'h6f: begin
        exp_st.push_back(JAL);   exp_mr.push_back(rb());
        exp_st.push_back(ALUWB); exp_mr.push_back(rb());
      end
      default: begin exp_st.push_back(FAULTS); exp_mr.push_back(rb()); end
    endcase
  endtask

  // {ResultSrc, ALUSrcA, ALUSrcB} the datapath needs in each step
  function automatic logic [5:0] exp_sel(input int s);
    case (s)
      FETCH:    return 6'b10_00_10;
      DECODE:   return 6'b00_01_01;
      MEMADR:   return 6'b00_10_01;
      MEMWB:    return 6'b01_00_00;
      EXECI:    return 6'b00_10_01;
      EXECR, BRANCH: return 6'b00_10_00;
      JAL:      return 6'b00_01_10;
      default:  return 6'b00_00_00;
    endcase
  endfunction

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input int sf, input int sm, input string tag,
                           output int n_ir, output int n_rw, output int n_mw, output int n_pc);
    int s;
    logic e_pc, e_ir, e_rw, e_mw, e_adr;
    logic [1:0] e_imm;
    logic [2:0] e_alu;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
    n_ir = 0; n_rw = 0; n_mw = 0; n_pc = 0;
    build_plan(o, f3, sf, sm);
    case (o)
      7'h23: e_imm = 2'b01;
      7'h63: e_imm = 2'b10;
      7'h6f: e_imm = 2'b11;
      default: e_imm = 2'b00;
    endcase
    foreach (exp_st[i]) begin
      @(negedge clk);
      mem_ready = exp_mr[i];
      #1;
      s = exp_st[i];
      e_ir  = (s == FETCH) && exp_mr[i];
      e_pc  = e_ir || (s == JAL) || (s == BRANCH && (z ? f3 == 3'd0 : f3 == 3'd1));
      e_rw  = (s == MEMWB) || (s == ALUWB);
      e_mw  = (s == MEMWRITE);
      e_adr = (s == MEMREAD) || (s == MEMWRITE);
      if (s == EXECR || s == EXECI) begin
        case (f3)
          3'b000:  e_alu = (o == 7'h33 && f7) ? 3'b001 : 3'b000;
          3'b010:  e_alu = 3'b101;
          3'b110:  e_alu = 3'b011;
          3'b111:  e_alu = 3'b010;
          default: e_alu = 3'b000;
        endcase
      end else e_alu = (s == BRANCH) ? 3'b001 : 3'b000;
      tests++;
      if (state_dbg !== 4'(s)) begin
        fails++; $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, state_dbg, s);
      end
      tests++;
      if ({PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc} !== {e_pc, e_ir, e_rw, e_mw, e_adr}) begin
        fails++; $display("FAIL %s enables cyc%0d: got %b want %b", tag, i,
          {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc}, {e_pc, e_ir, e_rw, e_mw, e_adr});
      end
      tests++;
      if ({ResultSrc, ALUSrcA, ALUSrcB} !== exp_sel(s)) begin
        fails++; $display("FAIL %s selects cyc%0d: got %b want %b", tag, i,
          {ResultSrc, ALUSrcA, ALUSrcB}, exp_sel(s));
      end
      tests++;
      if (ALUControl !== e_alu || ImmSrc !== e_imm || fault !== (s == FAULTS)) begin
        fails++; $display("FAIL %s alu/imm/fault cyc%0d: got %b/%b/%b want %b/%b/%b", tag, i,
          ALUControl, ImmSrc, fault, e_alu, e_imm, (s == FAULTS));
      end
      n_ir += int'(IRWrite); n_rw += int'(RegWrite);
      n_mw += int'(MemWrite); n_pc += int'(PCWrite);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    s = (exp_st[exp_st.size()-1] == FAULTS) ? FAULTS : FETCH;
    tests++;
    if (state_dbg !== 4'(s)) begin
      fails++; $display("FAIL %s end state: got %0d want %0d", tag, state_dbg, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (state_dbg !== 4'd0) begin fails++; $display("FAIL reset state: got %0d want 0", state_dbg); end
    tests++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
      fails++; $display("FAIL reset enables: got %b want 0000", {PCWrite, IRWrite, RegWrite, MemWrite});
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    tests++;
    if (state_dbg !== 4'd0 || IRWrite !== 1'b0) begin
      fails++; $display("FAIL reset release: got state %0d ir %b want 0 0", state_dbg, IRWrite);
    end
  endtask

  task automatic test_rtype();
    int a, b, c, d;
    run_instr(7'h33, 3'b000, 1'b1, 1'b0, 0, 0, "rtype_sub", a, b, c, d);
    tests++;
    if (a !== 1 || b !== 1) begin fails++; $display("FAIL rtype counts: ir %0d rw %0d want 1 1", a, b); end
  endtask

  task automatic test_lw_stall();
    int a, b, c, d;
    run_instr(7'h03, 3'b010, 1'b0, 1'b0, 2, 3, "lw_stall", a, b, c, d);
    tests++;
    if (exp_st.size() != 10 || a !== 1 || b !== 1) begin
      fails++; $display("FAIL lw_stall: cycles %0d ir %0d rw %0d want 10 1 1", exp_st.size(), a, b);
    end
  endtask

  task automatic test_sw();
    int a, b, c, d;
    run_instr(7'h23, 3'b010, 1'b0, 1'b0, 0, 0, "sw", a, b, c, d);
    tests++;
    if (c !== 1 || b !== 0) begin fails++; $display("FAIL sw counts: mw %0d rw %0d want 1 0", c, b); end
  endtask

  task automatic test_branch();
    int a, b, c, d, want;
    for (int f = 0; f < 2; f++) begin
      for (int z = 0; z < 2; z++) begin
        run_instr(7'h63, 3'(f), 1'b0, 1'(z), 0, 0, "branch", a, b, c, d);
        want = ((f == 0 && z == 1) || (f == 1 && z == 0)) ? 2 : 1;
        tests++;
        if (d !== want) begin
          fails++; $display("FAIL branch f3=%0d z=%0d pcwrites: got %0d want %0d", f, z, d, want);
        end
      end
    end
  endtask

  task automatic test_jal();
    int a, b, c, d;
    run_instr(7'h6f, 3'b000, 1'b0, 1'b0, 0, 0, "jal", a, b, c, d);
    tests++;
    if (d !== 2 || b !== 1) begin fails++; $display("FAIL jal counts: pc %0d rw %0d want 2 1", d, b); end
  endtask

  task automatic test_fault(input logic [6:0] o, input logic [2:0] f3);
    int a, b, c, d;
    run_instr(o, f3, 1'b0, 1'b0, 0, 0, "fault_entry", a, b, c, d);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ready = rb(); Zero = rb();
      #1;
      tests++;
      if (state_dbg !== 4'd15 || fault !== 1'b1 ||
          {PCWrite, IRWrite, RegWrite, MemWrite} !== 4'b0000) begin
        fails++; $display("FAIL fault hold op=%h cyc%0d: state %0d fault %b en %b want 15 1 0000",
          o, i, state_dbg, fault, {PCWrite, IRWrite, RegWrite, MemWrite});
      end
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; mem_ready = 1'b0;
    #1;
    tests++;
    if (state_dbg !== 4'd0 || fault !== 1'b0) begin
      fails++; $display("FAIL fault recover: state %0d fault %b want 0 0", state_dbg, fault);
    end
  endtask

  task automatic test_reset_mid_write();
    op = 7'h23; funct3 = 3'b010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = (i == 0);
    end
    #1;
    tests++;
    if (state_dbg !== 4'd5 || MemWrite !== 1'b1) begin
      fails++; $display("FAIL midwrite pre: state %0d mw %b want 5 1", state_dbg, MemWrite);
    end
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    tests++;
    if (MemWrite !== 1'b0 || PCWrite !== 1'b0) begin
      fails++; $display("FAIL midwrite during reset: mw %b pc %b want 0 0", MemWrite, PCWrite);
    end
    @(negedge clk);
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    tests++;
    if (state_dbg !== 4'd0 || MemWrite !== 1'b0) begin
      fails++; $display("FAIL midwrite after: state %0d mw %b want 0 0", state_dbg, MemWrite);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [6];
    logic [6:0] o;
    logic [2:0] f3;
    int a, b, c, d;
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33;
    ops[3] = 7'h13; ops[4] = 7'h63; ops[5] = 7'h6f;
    for (int n = 0; n < 40; n++) begin
      o  = ops[$urandom_range(0, 5)];
      f3 = (o == 7'h63) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr(o, f3, rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                "random", a, b, c, d);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_sw();
    test_branch();
    test_jal();
    test_fault(7'h7f, 3'b000);
    test_fault(7'h63, 3'b100);
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
